// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle RV32I sequencing FSM with memory req/ack handshake, retire counter and timeout trap.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes and expose the sticky illegal_o flag.
module control_multiciclo #(
  parameter int INSTRET_W    = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [6:0]           opcode_i,
  input  logic                 mem_ack_i,
  input  logic                 branch_taken_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 addr_sel_o,
  output logic                 ir_we_o,
  output logic [2:0]           imm_sel_o,
  output logic                 pc_we_o,
  output logic                 pc_sel_o,
  output logic                 rf_we_o,
  output logic [1:0]           wb_sel_o,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret_o,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_o,
`endif
  output logic                 err_o
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
  localparam logic [6:0] OP_ALUI = 7'b0010011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_ILL = 1'b1;
`else
  localparam logic TRAP_ILL = 1'b0;
`endif

  logic [2:0]           r_state, w_next;
  logic [6:0]           r_op, w_op;
  logic [WW-1:0]        r_wait;
  logic [INSTRET_W-1:0] r_instret;
  logic                 r_err;
  logic [2:0]           w_imm;
  logic                 w_alui, w_load, w_store, w_br, w_jal, w_known;
  logic                 w_req, w_tmo, w_illegal, w_retire;

  // DECODE sees the opcode live; later states use the copy latched in DECODE
  assign w_op      = (r_state == S_DECODE) ? opcode_i : r_op;
  assign w_alui    = w_op == OP_ALUI;
  assign w_load    = w_op == OP_LOAD;
  assign w_store   = w_op == OP_STORE;
  assign w_br      = w_op == OP_BR;
  assign w_jal     = w_op == OP_JAL;
  assign w_known   = w_alui || w_load || w_store || w_br || w_jal;
  assign w_imm     = (w_alui || w_load) ? 3'd1 : w_store ? 3'd2 : w_br ? 3'd3 : w_jal ? 3'd4 : 3'd0;
  assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_tmo     = w_req && !mem_ack_i && (r_wait == WW'(MEM_WAIT_MAX));
  assign w_illegal = (r_state == S_DECODE) && !w_known;
  assign w_retire  = (w_illegal && !TRAP_ILL) || ((r_state == S_EXEC) && w_br) ||
                     ((r_state == S_MEM) && w_store && mem_ack_i) || (r_state == S_WB);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = w_tmo ? S_TRAP : mem_ack_i ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_known ? S_EXEC : TRAP_ILL ? S_TRAP : S_FETCH;
      S_EXEC:   w_next = w_br ? S_FETCH : (w_load || w_store) ? S_MEM : S_WB;
      S_MEM:    w_next = w_tmo ? S_TRAP : !mem_ack_i ? S_MEM : w_store ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = w_req;
    mem_we_o   = (r_state == S_MEM) && w_store;
    addr_sel_o = r_state == S_MEM;
    ir_we_o    = (r_state == S_FETCH) && mem_ack_i;
    imm_sel_o  = (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) ? w_imm : 3'd0;
    pc_we_o    = w_retire;
    pc_sel_o   = ((r_state == S_EXEC) && w_br && branch_taken_i) || ((r_state == S_WB) && w_jal);
    rf_we_o    = r_state == S_WB;
    wb_sel_o   = (r_state != S_WB) ? 2'd0 : w_load ? 2'd1 : w_jal ? 2'd2 : 2'd0;
    state_o    = r_state;
    instret_o  = r_instret;
    err_o      = r_err;
  end

  // Wait counter restarts whenever the state changes, so it is fresh on every FETCH/MEM entry
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_op      <= '0;
      r_wait    <= '0;
      r_instret <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_op <= opcode_i;
      r_wait <= (w_next != r_state) ? '0 : (w_req && !mem_ack_i) ? r_wait + 1'b1 : r_wait;
      if (w_retire) r_instret <= r_instret + 1'b1;
      if (w_next == S_TRAP) r_err <= 1'b1;
    end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)        r_illegal <= 1'b0;
    else if (w_illegal) r_illegal <= 1'b1;
  assign illegal_o = r_illegal;
`endif
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: directed vectors for the multi-cycle control FSM; a negedge monitor pops expected snapshots.
module tb_control_multiciclo;
  localparam logic [2:0] I = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3, M = 3'd4, W = 3'd5, T = 3'd6;
  localparam logic [6:0] REQ = 7'b1000000, WE = 7'b0100000, AS = 7'b0010000, IRW = 7'b0001000,
                         PCW = 7'b0000100, PCS = 7'b0000010, RFW = 7'b0000001;
  localparam logic [6:0] OP_ALUI = 7'b0010011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

  logic        clk_i = 1'b0, rst_ni = 1'b0, mem_ack_i = 1'b0, branch_taken_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic        mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o, err_o;
  logic [2:0]  imm_sel_o, state_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] instret_o;
  logic        ill_act;

  control_multiciclo #(.INSTRET_W(32), .MEM_WAIT_MAX(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .mem_ack_i(mem_ack_i),
    .branch_taken_i(branch_taken_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .addr_sel_o(addr_sel_o), .ir_we_o(ir_we_o), .imm_sel_o(imm_sel_o), .pc_we_o(pc_we_o),
    .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .state_o(state_o),
    .instret_o(instret_o),
`ifdef ILLEGAL_TRAP_EN
    .illegal_o(ill_act),
`endif
    .err_o(err_o)
  );
`ifndef ILLEGAL_TRAP_EN
  assign ill_act = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [14:0] vec;
    logic [31:0] ir;
    logic        err;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  logic [31:0] exp_ir = '0;
  logic        exp_err = 1'b0, exp_ill = 1'b0;
  logic [14:0] act;

  assign act = {state_o, mem_req_o, mem_we_o, addr_sel_o, ir_we_o, imm_sel_o,
                pc_we_o, pc_sel_o, rf_we_o, wb_sel_o};

  always @(negedge clk_i)
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (act !== mon_e.vec || instret_o !== mon_e.ir || err_o !== mon_e.err || ill_act !== mon_e.ill) begin
        errors++;
        $display("FAIL %s: got vec=%b instret=%0d err=%b ill=%b, want vec=%b instret=%0d err=%b ill=%b",
                 mon_e.name, act, instret_o, err_o, ill_act, mon_e.vec, mon_e.ir, mon_e.err, mon_e.ill);
      end
    end

  task automatic step(input string n, input logic rst, input logic ack, input logic bt,
                      input logic [2:0] st, input logic [2:0] imm, input logic [6:0] f,
                      input logic [1:0] wb, input logic ret);
    exp_t e;
    rst_ni = rst;
    mem_ack_i = ack;
    branch_taken_i = bt;
    e.name = n;
    e.vec  = {st, f[6:3], imm, f[2:0], wb};
    e.ir   = exp_ir;
    e.err  = exp_err;
    e.ill  = exp_ill;
    q.push_back(e);
    @(posedge clk_i);
    #1;
    if (ret) exp_ir++;
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    step("reset", 0, 0, 0, I, 0, 0, 0, 0);
    step("idle", 1, 0, 0, I, 0, 0, 0, 0);
    opcode_i = OP_ALUI;
    step("alu_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("alu_dec", 1, 0, 0, D, 1, 0, 0, 0);
    step("alu_exec_ack_ignored", 1, 1, 0, E, 1, 0, 0, 0);
    step("alu_wb", 1, 0, 0, W, 1, PCW | RFW, 0, 1);
    opcode_i = OP_LOAD;
    step("ld_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("ld_dec", 1, 0, 0, D, 1, 0, 0, 0);
    step("ld_exec", 1, 0, 0, E, 1, 0, 0, 0);
    step("ld_mem_wait0", 1, 0, 0, M, 1, REQ | AS, 0, 0);
    step("ld_mem_wait1", 1, 0, 0, M, 1, REQ | AS, 0, 0);
    step("ld_mem_ack", 1, 1, 0, M, 1, REQ | AS, 0, 0);
    step("ld_wb", 1, 0, 0, W, 1, PCW | RFW, 1, 1);
    opcode_i = OP_BR;
    step("br_t_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("br_t_dec", 1, 0, 1, D, 3, 0, 0, 0);
    step("br_t_exec", 1, 0, 1, E, 3, PCW | PCS, 0, 1);
    step("br_n_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("br_n_dec", 1, 0, 0, D, 3, 0, 0, 0);
    step("br_n_exec", 1, 0, 0, E, 3, PCW, 0, 1);
    opcode_i = OP_STORE;
    step("st_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("st_dec", 1, 0, 0, D, 2, 0, 0, 0);
    step("st_exec", 1, 0, 0, E, 2, 0, 0, 0);
    step("st_mem_ack", 1, 1, 0, M, 2, REQ | WE | AS | PCW, 0, 1);
    opcode_i = OP_JAL;
    step("jal_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("jal_dec", 1, 0, 0, D, 4, 0, 0, 0);
    step("jal_exec", 1, 0, 0, E, 4, 0, 0, 0);
    step("jal_wb", 1, 0, 0, W, 4, PCW | PCS | RFW, 2, 1);
    opcode_i = OP_BAD;
    step("ill_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    step("ill_dec", 1, 0, 0, D, 0, 0, 0, 0);
    exp_err = 1'b1;
    exp_ill = 1'b1;
    step("ill_trap", 1, 1, 0, T, 0, 0, 0, 0);
`else
    step("ill_dec_nop", 1, 0, 0, D, 0, PCW, 0, 1);
    step("ill_next_fetch", 1, 0, 0, F, 0, REQ, 0, 0);
`endif
    exp_ir = '0;
    exp_err = 1'b0;
    exp_ill = 1'b0;
    step("reset2", 0, 0, 0, I, 0, 0, 0, 0);
    step("idle2", 1, 0, 0, I, 0, 0, 0, 0);
    opcode_i = OP_LOAD;
    step("ld2_fetch", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("ld2_dec", 1, 0, 0, D, 1, 0, 0, 0);
    step("ld2_exec", 1, 0, 0, E, 1, 0, 0, 0);
    step("ld2_mem", 1, 0, 0, M, 1, REQ | AS, 0, 0);
    step("rst_mid_mem", 0, 1, 0, I, 0, 0, 0, 0);
    step("idle3", 1, 0, 0, I, 0, 0, 0, 0);
    opcode_i = OP_ALUI;
    for (int i = 0; i < 15; i++) step("fetch_wait", 1, 0, 0, F, 0, REQ, 0, 0);
    step("fetch_ack_at_max", 1, 1, 0, F, 0, REQ | IRW, 0, 0);
    step("alu2_dec", 1, 0, 0, D, 1, 0, 0, 0);
    step("alu2_exec", 1, 0, 0, E, 1, 0, 0, 0);
    step("alu2_wb", 1, 0, 0, W, 1, PCW | RFW, 0, 1);
    for (int i = 0; i < 16; i++) step("fetch_timeout_wait", 1, 0, 0, F, 0, REQ, 0, 0);
    exp_err = 1'b1;
    step("trap", 1, 1, 0, T, 0, 0, 0, 0);
    step("trap_hold", 1, 1, 0, T, 0, 0, 0, 0);
    exp_ir = '0;
    exp_err = 1'b0;
    step("trap_reset", 0, 0, 0, I, 0, 0, 0, 0);
    step("idle_after_trap", 1, 0, 0, I, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Multi-cycle sequencing FSM for the RV32I datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back, with a req/ack handshake to the shared instruction/data memory.
- Drives the immediate-format select consumed by the sign-extension unit, plus the PC, register-file, memory and mux strobes.
- Counts retired instructions and flags memory timeouts.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter (wraps modulo 2^INSTRET_W).
- MEM_WAIT_MAX, 15, maximum wait cycles for mem_ack_i before trapping; minimum legal value 1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset
- opcode_i  input  7  instruction[6:0] from the instruction register
- mem_ack_i  input  1  memory completes current request this cycle
- branch_taken_i  input  1  branch comparator result, sampled in EXEC
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write (store)
- addr_sel_o  output  1  memory address source: 0 = PC, 1 = ALU result
- ir_we_o  output  1  instruction-register load strobe
- imm_sel_o  output  3  0 none, 1 I/Load, 2 S, 3 B, 4 J
- pc_we_o  output  1  PC write strobe
- pc_sel_o  output  1  next PC: 0 = PC+4, 1 = PC+imm
- rf_we_o  output  1  register-file write
- wb_sel_o  output  2  write-back source: 0 ALU, 1 memory, 2 PC+4
- state_o  output  3  current state encoding
- instret_o  output  INSTRET_W  retired-instruction count
- err_o  output  1  sticky error

Interface (already decided):
- Single clock clk_i.
- rst_ni is asynchronous, active-low.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Strobes are Moore-decoded from state and the latched opcode op_q. mem_ack_i-qualified strobes are combinational in the ack cycle.
- Reset: state IDLE; all strobes 0; imm_sel_o 0; op_q 0; instret_o 0; err_o 0; wait counter 0.
- Reset mid-operation: asserting rst_ni aborts any state, including mid-handshake, and the request drops immediately.
- IDLE: -> FETCH unconditionally on the next cycle.
- FETCH:
  - mem_req_o=1, addr_sel_o=0, mem_we_o=0.
  - On mem_ack_i: ir_we_o=1 in the same cycle, then -> DECODE.
- DECODE:
  - Latch op_q <= opcode_i.
  - Opcode map: 0010011 ALU-I (imm 1); 0000011 Load (imm 1); 0100011 Store (imm 2); 1100011 Branch (imm 3); 1101111 JAL (imm 4).
  - Any other opcode: pc_we_o=1, pc_sel_o=0, instret++, -> FETCH (NOP).
  - Otherwise -> EXEC.
- imm_sel_o is valid from DECODE through the end of WB/MEM and is 0 in IDLE/FETCH/TRAP.
- EXEC:
  - Branch: pc_we_o=1, pc_sel_o=branch_taken_i, instret++, -> FETCH.
  - Load/Store: -> MEM.
  - ALU-I/JAL: -> WB.
- MEM:
  - mem_req_o=1, addr_sel_o=1, mem_we_o = (op_q==Store).
  - On ack: Store does pc_we_o=1, pc_sel_o=0, instret++, -> FETCH. Load -> WB.
- WB:
  - rf_we_o=1, pc_we_o=1, instret++, -> FETCH.
  - wb_sel_o: 0 for ALU-I, 1 for Load, 2 for JAL.
  - pc_sel_o = 1 for JAL, else 0.
- Cycles per instruction with zero-wait memory: Branch 3, ALU-I/JAL 4, Store 4, Load 5.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each request cycle without ack.
  - If it equals MEM_WAIT_MAX and mem_ack_i=0: -> TRAP, err_o<=1.
  - An ack in that same cycle wins (no trap).
- TRAP: all strobes 0, err_o held 1. Exits only via reset.
- mem_ack_i outside FETCH/MEM is ignored.
- instret_o wraps to 0 after all-ones. Each retired instruction increments it exactly once.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE -> TRAP with err_o=1.
  - Additional output illegal_o (1 bit, reset 0) is set sticky alongside err_o.
  - instret_o is not incremented.
- Undefined: unknown opcodes execute as NOP as described above; illegal_o is absent.

Test Plan:
- Reset/ALU-I: release reset, opcode_i=0010011, ack on first FETCH cycle -> state sequence 0,1,2,3,5,1; imm_sel_o=1 in DECODE..WB; rf_we_o=1 and pc_we_o=1 in WB; instret_o=1.
- Load with 2-cycle memory wait: opcode 0000011, ack two cycles after MEM entry -> mem_we_o=0, addr_sel_o=1 for 3 cycles; then WB with wb_sel_o=1; instret_o increments by 1.
- Branch taken/not taken: opcode 1100011 with branch_taken_i=1 -> pc_sel_o=1, imm_sel_o=3, FETCH after 3 cycles; with branch_taken_i=0 -> pc_sel_o=0.
- Store and JAL:
  - Store (0100011): mem_we_o=1 in MEM, imm_sel_o=2, rf_we_o never 1.
  - JAL (1101111): WB with wb_sel_o=2, pc_sel_o=1, imm_sel_o=4.
- Timeout: hold mem_ack_i=0 in FETCH -> TRAP after MEM_WAIT_MAX (15) wait cycles; err_o=1, mem_req_o=0; remains in TRAP until rst_ni low, then IDLE with err_o=0.
- Illegal opcode 1111111:
  - Macro undefined: NOP, pc_we_o=1, instret+1.
  - ILLEGAL_TRAP_EN defined: TRAP, err_o=1, illegal_o=1, instret_o unchanged.
  - Also assert rst_ni mid-MEM: mem_req_o drops immediately and state_o=0.
